// File: rtl/execute_stage_pkg.sv
// Shared decode/execute definitions: func codes, FSM states and op-classification helpers.
package execute_stage_pkg;

    localparam logic [5:0] FN_NOP   = 6'd0;
    localparam logic [5:0] FN_ADD   = 6'd1;
    localparam logic [5:0] FN_ADDI  = 6'd2;
    localparam logic [5:0] FN_SUB   = 6'd3;
    localparam logic [5:0] FN_SLL   = 6'd4;
    localparam logic [5:0] FN_SLLI  = 6'd5;
    localparam logic [5:0] FN_SRL   = 6'd6;
    localparam logic [5:0] FN_SRLI  = 6'd7;
    localparam logic [5:0] FN_SRA   = 6'd8;
    localparam logic [5:0] FN_SRAI  = 6'd9;
    localparam logic [5:0] FN_SLT   = 6'd10;
    localparam logic [5:0] FN_SLTI  = 6'd11;
    localparam logic [5:0] FN_SLTU  = 6'd12;
    localparam logic [5:0] FN_SLTIU = 6'd13;
    localparam logic [5:0] FN_XOR   = 6'd14;
    localparam logic [5:0] FN_XORI  = 6'd15;
    localparam logic [5:0] FN_OR    = 6'd16;
    localparam logic [5:0] FN_ORI   = 6'd17;
    localparam logic [5:0] FN_AND   = 6'd18;
    localparam logic [5:0] FN_ANDI  = 6'd19;
    localparam logic [5:0] FN_LUI   = 6'd20;
    localparam logic [5:0] FN_AUIPC = 6'd21;
    localparam logic [5:0] FN_JAL   = 6'd22;
    localparam logic [5:0] FN_JALR  = 6'd23;
    localparam logic [5:0] FN_BEQ   = 6'd24;
    localparam logic [5:0] FN_BNE   = 6'd25;
    localparam logic [5:0] FN_BLT   = 6'd26;
    localparam logic [5:0] FN_BGE   = 6'd27;
    localparam logic [5:0] FN_BLTU  = 6'd28;
    localparam logic [5:0] FN_BGEU  = 6'd29;
    localparam logic [5:0] FN_LB    = 6'd30;
    localparam logic [5:0] FN_LH    = 6'd31;
    localparam logic [5:0] FN_LW    = 6'd32;
    localparam logic [5:0] FN_LBU   = 6'd33;
    localparam logic [5:0] FN_LHU   = 6'd34;
    localparam logic [5:0] FN_SB    = 6'd35;
    localparam logic [5:0] FN_SH    = 6'd36;
    localparam logic [5:0] FN_SW    = 6'd37;

    typedef enum logic {
        ST_IDLE,
        ST_MEM_WAIT
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } mem_size_t;

    function automatic logic is_load(input logic [5:0] f);
        return f inside {FN_LB, FN_LH, FN_LW, FN_LBU, FN_LHU};
    endfunction

    function automatic logic is_store(input logic [5:0] f);
        return f inside {FN_SB, FN_SH, FN_SW};
    endfunction

    function automatic logic is_mem(input logic [5:0] f);
        return is_load(f) || is_store(f);
    endfunction

    function automatic logic is_branch(input logic [5:0] f);
        return f inside {FN_BEQ, FN_BNE, FN_BLT, FN_BGE, FN_BLTU, FN_BGEU};
    endfunction

    function automatic logic is_jump(input logic [5:0] f);
        return f inside {FN_JAL, FN_JALR};
    endfunction

    // Ops that produce a register result outside the memory path.
    function automatic logic writes_reg(input logic [5:0] f);
        return !(f == FN_NOP || is_branch(f) || is_mem(f));
    endfunction

    function automatic mem_size_t mem_size(input logic [5:0] f);
        if (f inside {FN_LB, FN_LBU, FN_SB})
            return SZ_BYTE;
        else if (f inside {FN_LH, FN_LHU, FN_SH})
            return SZ_HALF;
        else
            return SZ_WORD;
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU: arithmetic/logic result, branch/jump decision and r+l based jump target.
module exec_alu
    import execute_stage_pkg::*;
#(
    parameter int width = 32
) (
    input  logic [5:0]       func,
    input  logic [width-1:0] l,
    input  logic [width-1:0] r,
    output logic [width-1:0] result,
    output logic             taken,
    output logic [width-1:0] target
);

    logic [width-1:0] sum;

    assign sum = r + l;

    // Memory ops fall through to the default so result doubles as the effective address.
    always_comb begin
        result = sum;
        taken  = 1'b0;
        target = sum;
        case (func)
            FN_SUB:                     result = r - l;
            FN_SLL,  FN_SLLI:           result = r << l[4:0];
            FN_SRL,  FN_SRLI:           result = r >> l[4:0];
            FN_SRA,  FN_SRAI:           result = $signed(r) >>> l[4:0];
            FN_SLT,  FN_SLTI:           result = {{(width-1){1'b0}}, $signed(r) < $signed(l)};
            FN_SLTU, FN_SLTIU:          result = {{(width-1){1'b0}}, r < l};
            FN_XOR,  FN_XORI:           result = r ^ l;
            FN_OR,   FN_ORI:            result = r | l;
            FN_AND,  FN_ANDI:           result = r & l;
            FN_JAL:                     taken  = 1'b1;
            FN_JALR: begin
                taken  = 1'b1;
                target = {sum[width-1:1], 1'b0};
            end
            FN_BEQ:                     taken  = (r == l);
            FN_BNE:                     taken  = (r != l);
            FN_BLT:                     taken  = $signed(r) < $signed(l);
            FN_BGE:                     taken  = $signed(r) >= $signed(l);
            FN_BLTU:                    taken  = r < l;
            FN_BGEU:                    taken  = r >= l;
            default: ;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU, branch resolution and req/ack load/store unit with registered writeback.
// Optional MISALIGN_TRAP_EN suppresses misaligned accesses and raises a sticky misalign flag.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       func,
    input  logic [4:0]       rd,
    input  logic             rdv,
    input  logic [width-1:0] left,
    input  logic [width-1:0] right,
    input  logic [width-1:0] extra,
    output logic             stall,
    output logic             jmp,
    output logic [width-1:0] jmp_target,
    output logic [4:0]       wb_rd,
    output logic             wb_rdv,
    output logic [width-1:0] wb_data,
    output logic             mem_req,
    output logic             mem_we,
    output logic [width-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [width-1:0] mem_wdata,
    input  logic [width-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             misalign
);

    logic [5:0]       s_func;
    logic [4:0]       s_rd;
    logic             s_rdv;
    logic [width-1:0] s_left;
    logic [width-1:0] s_right;
    logic [width-1:0] s_extra;

    logic [width-1:0] alu_result;
    logic             alu_taken;
    logic [width-1:0] alu_target;
    logic [width-1:0] exec_result;
    logic [width-1:0] addr;
    mem_size_t        size;
    logic [3:0]       be;
    logic [width-1:0] wdata;
    logic [width-1:0] byte_lane;
    logic [width-1:0] half_lane;
    logic [width-1:0] load_data;
    logic             mis_mem;
    logic             mem_go;

    state_t state_q;
    state_t state_d;

    // Stage register holds the op in place for the whole memory access.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_func  <= FN_NOP;
            s_rd    <= '0;
            s_rdv   <= 1'b0;
            s_left  <= '0;
            s_right <= '0;
            s_extra <= '0;
        end else if (!stall) begin
            s_func  <= func;
            s_rd    <= rd;
            s_rdv   <= rdv;
            s_left  <= left;
            s_right <= right;
            s_extra <= extra;
        end
    end

    exec_alu #(.width(width)) u_alu (
        .func   (s_func),
        .l      (s_left),
        .r      (s_right),
        .result (alu_result),
        .taken  (alu_taken),
        .target (alu_target)
    );

    assign exec_result = (s_func inside {FN_LUI, FN_JAL, FN_JALR}) ? s_extra : alu_result;
    assign jmp         = alu_taken;
    assign jmp_target  = is_branch(s_func) ? s_extra : alu_target;
    assign addr        = alu_result;
    assign size        = mem_size(s_func);

    always_comb begin
        be    = 4'b1111;
        wdata = s_extra;
        case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << addr[1:0];
                wdata = {4{s_extra[7:0]}};
            end
            SZ_HALF: begin
                be    = 4'b0011 << {addr[1], 1'b0};
                wdata = {2{s_extra[15:0]}};
            end
            default: ;
        endcase
    end

    assign byte_lane = mem_rdata >> {addr[1:0], 3'b000};
    assign half_lane = mem_rdata >> {addr[1], 4'b0000};

    always_comb begin
        load_data = mem_rdata;
        case (s_func)
            FN_LB:  load_data = {{24{byte_lane[7]}}, byte_lane[7:0]};
            FN_LBU: load_data = {24'd0, byte_lane[7:0]};
            FN_LH:  load_data = {{16{half_lane[15]}}, half_lane[15:0]};
            FN_LHU: load_data = {16'd0, half_lane[15:0]};
            default: ;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic mis_jmp;
    logic misalign_q;

    assign mis_mem = is_mem(s_func) &&
                     ((size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00));
    assign mis_jmp = is_jump(s_func) && alu_target[1];

    always_ff @(posedge clk) begin
        if (rst)
            misalign_q <= 1'b0;
        else if (mis_mem || mis_jmp)
            misalign_q <= 1'b1;
    end

    assign misalign = misalign_q;
`else
    assign mis_mem  = 1'b0;
    assign misalign = 1'b0;
`endif

    assign mem_go = is_mem(s_func) && !mis_mem;

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // The ack cycle releases stall so the stage register advances on the same edge.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_go) begin
                    stall   = 1'b1;
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ack)
                    state_d = ST_IDLE;
                else
                    stall = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
        end else if (state_q == ST_IDLE && mem_go) begin
            mem_req   <= 1'b1;
            mem_we    <= is_store(s_func);
            mem_addr  <= addr;
            mem_be    <= be;
            mem_wdata <= wdata;
        end else if (state_q == ST_MEM_WAIT && mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
        end
    end

    // wb_rdv is a one-cycle pulse per result; idle cycles clear it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_rdv  <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else begin
            wb_rdv <= 1'b0;
            if (state_q == ST_IDLE && writes_reg(s_func)) begin
                wb_rdv  <= s_rdv;
                wb_rd   <= s_rd;
                wb_data <= exec_result;
            end else if (state_q == ST_MEM_WAIT && mem_ack && is_load(s_func)) begin
                wb_rdv  <= s_rdv;
                wb_rd   <= s_rd;
                wb_data <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: expected writebacks are queued at issue and popped by a monitor.
module tb_execute_stage;
    import execute_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  func;
    logic [4:0]  rd;
    logic        rdv;
    logic [31:0] left;
    logic [31:0] right;
    logic [31:0] extra;
    logic        stall;
    logic        jmp;
    logic [31:0] jmp_target;
    logic [4:0]  wb_rd;
    logic        wb_rdv;
    logic [31:0] wb_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        misalign;

    int checks   = 0;
    int failures = 0;
    logic [36:0] sb_q[$];
    logic [36:0] mon_exp;

    execute_stage #(.width(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .func       (func),
        .rd         (rd),
        .rdv        (rdv),
        .left       (left),
        .right      (right),
        .extra      (extra),
        .stall      (stall),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .wb_rd      (wb_rd),
        .wb_rdv     (wb_rdv),
        .wb_data    (wb_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic expectWb(input logic [4:0] d, input logic [31:0] data);
        sb_q.push_back({d, data});
    endtask

    // Drive one op; returns one tick after the edge that captured it.
    task automatic applyStimulus(input logic [5:0] f, input logic [4:0] d, input logic dv,
                                 input logic [31:0] l, input logic [31:0] r, input logic [31:0] x);
        func  = f;
        rd    = d;
        rdv   = dv;
        left  = l;
        right = r;
        extra = x;
        @(posedge clk);
        #1;
    endtask

    task automatic doMem(input logic [5:0] f, input logic [4:0] d, input logic [31:0] l,
                         input logic [31:0] r, input logic [31:0] x, input int delay,
                         input logic [31:0] rdata, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_load);
        logic st;
        st = (f == FN_SB || f == FN_SH || f == FN_SW);
        if (!st)
            expectWb(d, exp_load);
        applyStimulus(f, d, 1'b1, l, r, x);
        checkOutput("mem_stall_issue", 32'(stall), 32'd1);
        checkOutput("mem_req_early", 32'(mem_req), 32'd0);
        applyStimulus(FN_NOP, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        checkOutput("mem_req", 32'(mem_req), 32'd1);
        checkOutput("mem_addr", mem_addr, r + l);
        checkOutput("mem_be", 32'(mem_be), 32'(exp_be));
        checkOutput("mem_we", 32'(mem_we), 32'(st));
        if (st)
            checkOutput("mem_wdata", mem_wdata, exp_wdata);
        for (int i = 0; i < delay; i++) begin
            @(posedge clk);
            #1;
            checkOutput("mem_wait_stall", 32'(stall), 32'd1);
            checkOutput("mem_wait_req", 32'(mem_req), 32'd1);
            checkOutput("mem_wait_addr", mem_addr, r + l);
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        #1;
        checkOutput("mem_ack_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        checkOutput("mem_req_drop", 32'(mem_req), 32'd0);
        checkOutput("mem_after_stall", 32'(stall), 32'd0);
    endtask

    // Every writeback pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && wb_rdv) begin
            if (sb_q.size() == 0) begin
                checkOutput("wb_unexpected", 32'(wb_rdv), 32'd0);
            end else begin
                mon_exp = sb_q.pop_front();
                checkOutput("wb_rd", 32'(wb_rd), 32'(mon_exp[36:32]));
                checkOutput("wb_data", wb_data, mon_exp[31:0]);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        func      = FN_NOP;
        rd        = '0;
        rdv       = 1'b0;
        left      = '0;
        right     = '0;
        extra     = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_wb_rdv", 32'(wb_rdv), 32'd0);
        checkOutput("rst_wb_rd", 32'(wb_rd), 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_be", 32'(mem_be), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_jmp", 32'(jmp), 32'd0);
        checkOutput("rst_misalign", 32'(misalign), 32'd0);
        rst = 1'b0;

        expectWb(5'd5, 32'h8000_0000);
        applyStimulus(FN_ADD, 5'd5, 1'b1, 32'h1, 32'h7FFF_FFFF, 32'd0);
        expectWb(5'd6, 32'hC000_0000);
        applyStimulus(FN_SRA, 5'd6, 1'b1, 32'h21, 32'h8000_0000, 32'd0);
        expectWb(5'd7, 32'd1);
        applyStimulus(FN_SLTU, 5'd7, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0);
        expectWb(5'd8, 32'd0);
        applyStimulus(FN_SLT, 5'd8, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0);
        expectWb(5'd9, 32'hFFFF_FFFE);
        applyStimulus(FN_SUB, 5'd9, 1'b1, 32'd7, 32'd5, 32'd0);
        expectWb(5'd10, 32'h30);
        applyStimulus(FN_SLLI, 5'd10, 1'b1, 32'h24, 32'd3, 32'd0);
        expectWb(5'd11, 32'h0800_0000);
        applyStimulus(FN_SRL, 5'd11, 1'b1, 32'd4, 32'h8000_0000, 32'd0);
        expectWb(5'd12, 32'h0FF0_0FF0);
        applyStimulus(FN_XOR, 5'd12, 1'b1, 32'hFF00_FF00, 32'hF0F0_F0F0, 32'd0);
        expectWb(5'd13, 32'hF000_F000);
        applyStimulus(FN_AND, 5'd13, 1'b1, 32'hFF00_FF00, 32'hF0F0_F0F0, 32'd0);
        expectWb(5'd14, 32'hFFF0_FFF0);
        applyStimulus(FN_OR, 5'd14, 1'b1, 32'hFF00_FF00, 32'hF0F0_F0F0, 32'd0);
        expectWb(5'd15, 32'hABCD_E000);
        applyStimulus(FN_LUI, 5'd15, 1'b1, 32'd0, 32'd0, 32'hABCD_E000);
        expectWb(5'd16, 32'h6000);
        applyStimulus(FN_AUIPC, 5'd16, 1'b1, 32'h5000, 32'h1000, 32'd0);
        applyStimulus(FN_ADD, 5'd17, 1'b0, 32'd1, 32'd1, 32'd0);

        applyStimulus(FN_BNE, 5'd0, 1'b0, 32'd4, 32'd3, 32'h100);
        checkOutput("bne_jmp", 32'(jmp), 32'd1);
        checkOutput("bne_target", jmp_target, 32'h100);
        checkOutput("bne_stall", 32'(stall), 32'd0);
        applyStimulus(FN_BEQ, 5'd0, 1'b0, 32'd4, 32'd3, 32'h100);
        checkOutput("beq_jmp", 32'(jmp), 32'd0);
        applyStimulus(FN_BGEU, 5'd0, 1'b0, 32'd4, 32'hFFFF_FFFF, 32'h200);
        checkOutput("bgeu_jmp", 32'(jmp), 32'd1);
        checkOutput("bgeu_target", jmp_target, 32'h200);
        expectWb(5'd1, 32'h1004);
        applyStimulus(FN_JAL, 5'd1, 1'b1, 32'h20, 32'h1000, 32'h1004);
        checkOutput("jal_jmp", 32'(jmp), 32'd1);
        checkOutput("jal_target", jmp_target, 32'h1020);
        expectWb(5'd2, 32'h44);
        applyStimulus(FN_JALR, 5'd2, 1'b1, 32'h10, 32'h2001, 32'h44);
        checkOutput("jalr_jmp", 32'(jmp), 32'd1);
        checkOutput("jalr_target", jmp_target, 32'h2010);
        applyStimulus(FN_NOP, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        checkOutput("jmp_one_cycle", 32'(jmp), 32'd0);

        doMem(FN_LB,  5'd3, 32'd3, 32'h1000, 32'd0, 3, 32'h80AA_BBCC, 4'b1000, 32'd0, 32'hFFFF_FF80);
        doMem(FN_LHU, 5'd4, 32'd2, 32'h1000, 32'd0, 0, 32'h80AA_BBCC, 4'b1100, 32'd0, 32'h0000_80AA);
        doMem(FN_LH,  5'd5, 32'd0, 32'h1000, 32'd0, 1, 32'h1234_F00D, 4'b0011, 32'd0, 32'hFFFF_F00D);
        doMem(FN_LW,  5'd6, 32'd4, 32'h0100, 32'd0, 1, 32'hCAFE_BABE, 4'b1111, 32'd0, 32'hCAFE_BABE);
        doMem(FN_SH,  5'd7, 32'd2, 32'h2000, 32'h1234_ABCD, 2, 32'd0, 4'b1100, 32'hABCD_ABCD, 32'd0);
        doMem(FN_SB,  5'd8, 32'd1, 32'h3000, 32'h0000_00EF, 0, 32'd0, 4'b0010, 32'hEFEF_EFEF, 32'd0);
        doMem(FN_SW,  5'd9, 32'd8, 32'h3000, 32'h1122_3344, 1, 32'd0, 4'b1111, 32'h1122_3344, 32'd0);

        mem_ack = 1'b1;
        applyStimulus(FN_NOP, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        mem_ack = 1'b0;
        checkOutput("idle_ack_req", 32'(mem_req), 32'd0);
        checkOutput("idle_ack_stall", 32'(stall), 32'd0);

        applyStimulus(FN_LW, 5'd10, 1'b1, 32'd0, 32'h4000, 32'd0);
        applyStimulus(FN_NOP, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        checkOutput("rstwait_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstwait_req_drop", 32'(mem_req), 32'd0);
        checkOutput("rstwait_stall", 32'(stall), 32'd0);
        checkOutput("rstwait_wb_rdv", 32'(wb_rdv), 32'd0);
        rst = 1'b0;

`ifdef MISALIGN_TRAP_EN
        applyStimulus(FN_LW, 5'd12, 1'b1, 32'd2, 32'd0, 32'd0);
        checkOutput("mis_stall", 32'(stall), 32'd0);
        applyStimulus(FN_NOP, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        checkOutput("mis_req", 32'(mem_req), 32'd0);
        checkOutput("mis_flag", 32'(misalign), 32'd1);
        applyStimulus(FN_NOP, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        checkOutput("mis_sticky", 32'(misalign), 32'd1);
`else
        doMem(FN_LW, 5'd12, 32'd2, 32'd0, 32'd0, 0, 32'hDEAD_BEEF, 4'b1111, 32'd0, 32'hDEAD_BEEF);
        checkOutput("mis_flag_off", 32'(misalign), 32'd0);
`endif

        repeat (3) applyStimulus(FN_NOP, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        checkOutput("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
